// File: rtl/pe_nic.sv
// Network interface between one processing element and the PE port of a ring router.
// Single-entry outbound and inbound packet buffers behind a 4-address register window.
module pe_nic #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  input  logic             nic_en,
  input  logic             nic_wr_en,
  output logic             net_si,
  input  logic             net_ri,
  output logic [WIDTH-1:0] net_do,
  input  logic             net_so,
  output logic             net_ro,
  input  logic [WIDTH-1:0] net_di,
  input  logic             net_polarity
);

  localparam logic [1:0] ADDR_IN_DATA    = 2'b00;
  localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
  localparam logic [1:0] ADDR_OUT_DATA   = 2'b10;
  localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

  logic [WIDTH-1:0] r_out_buf;
  logic             r_out_full;
  logic [WIDTH-1:0] r_in_buf;
  logic             r_in_full;
  logic [WIDTH-1:0] r_d_out;

  logic w_wr_out;
  logic w_rd;
  logic w_rd_in_data;
  logic w_inject;
  logic w_capture;

  assign w_wr_out     = nic_en & nic_wr_en & (addr == ADDR_OUT_DATA);
  assign w_rd         = nic_en & ~nic_wr_en;
  assign w_rd_in_data = w_rd & (addr == ADDR_IN_DATA);

  // A packet may only enter the ring on the phase matching its VC bit.
  assign w_inject  = r_out_full & net_ri & (r_out_buf[WIDTH-1] == net_polarity);
  assign w_capture = net_so & ~r_in_full;

  assign net_si = w_inject;
  assign net_do = r_out_buf;
  assign net_ro = ~r_in_full;
  assign d_out  = r_d_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_buf  <= '0;
      r_out_full <= 1'b0;
    end else if (w_inject) begin
      r_out_full <= 1'b0;
    end else if (w_wr_out && !r_out_full) begin
      r_out_buf  <= d_in;
      r_out_full <= 1'b1;
    end
  end

  // Capture is placed after the read-clear so a same-edge arrival keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_buf  <= '0;
      r_in_full <= 1'b0;
    end else begin
      if (w_rd_in_data) begin
        r_in_full <= 1'b0;
      end
      if (w_capture) begin
        r_in_buf  <= net_di;
        r_in_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_out <= '0;
    end else if (w_rd) begin
      case (addr)
        ADDR_IN_DATA:    r_d_out <= r_in_buf;
        ADDR_IN_STATUS:  r_d_out <= {{(WIDTH-1){1'b0}}, r_in_full};
        ADDR_OUT_STATUS: r_d_out <= {{(WIDTH-1){1'b0}}, r_out_full};
        default:         r_d_out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_nic.sv
// Scoreboard bench for pe_nic: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_pe_nic;

  localparam int W = 64;

  logic          clk;
  logic          rst;
  logic [1:0]    addr;
  logic [W-1:0]  d_in;
  logic [W-1:0]  d_out;
  logic          nic_en;
  logic          nic_wr_en;
  logic          net_si;
  logic          net_ri;
  logic [W-1:0]  net_do;
  logic          net_so;
  logic          net_ro;
  logic [W-1:0]  net_di;
  logic          net_polarity;

  pe_nic #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nic_en(nic_en), .nic_wr_en(nic_wr_en),
    .net_si(net_si), .net_ri(net_ri), .net_do(net_do),
    .net_so(net_so), .net_ro(net_ro), .net_di(net_di),
    .net_polarity(net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         si;
    logic         ro;
    logic         dz;
    logic [W-1:0] pkt;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] rd_q[$];

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  armed    = 1'b0;

  // Reference model: outbound/inbound slots as bounded queues plus the last packet latched in.
  logic [W-1:0] m_out_q[$];
  logic [W-1:0] m_in_q[$];
  logic [W-1:0] m_in_last;
  bit           m_dz;

  function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  task automatic step(input logic en, input logic wr, input logic [1:0] a, input logic [W-1:0] din,
                      input logic ri, input logic so, input logic [W-1:0] di, input logic rs);
    exp_t e;
    bit   inj;
    bit   in_full_pre;
    rst = rs; nic_en = en; nic_wr_en = wr; addr = a; d_in = din;
    net_ri = ri; net_so = so; net_di = di;
    inj = (m_out_q.size() == 1) && ri && (m_out_q[0][W-1] == net_polarity);
    e.si  = inj;
    e.ro  = (m_in_q.size() == 0);
    e.dz  = m_dz;
    e.pkt = inj ? m_out_q[0] : '0;
    exp_q.push_back(e);
    m_dz = 1'b0;
    if (en && !wr && !rs) begin
      case (a)
        2'b00:   rd_q.push_back(m_in_last);
        2'b01:   rd_q.push_back(W'(m_in_q.size()));
        2'b11:   rd_q.push_back(W'(m_out_q.size()));
        default: rd_q.push_back('0);
      endcase
    end
    @(posedge clk);
    #1;
    if (rs) begin
      m_out_q.delete();
      m_in_q.delete();
      m_in_last = '0;
      m_dz = 1'b1;
    end else begin
      in_full_pre = (m_in_q.size() == 1);
      if (inj) void'(m_out_q.pop_front());
      else if (en && wr && a == 2'b10 && m_out_q.size() == 0) m_out_q.push_back(din);
      if (en && !wr && a == 2'b00) m_in_q.delete();
      if (so && !in_full_pre) begin
        m_in_q.delete();
        m_in_q.push_back(di);
        m_in_last = di;
      end
    end
    net_polarity = ~net_polarity;
  endtask

  task automatic idle(input logic ri, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, '0, ri, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] a, input logic ri);
    step(1'b1, 1'b0, a, '0, ri, 1'b0, '0, 1'b0);
  endtask

  task automatic wr_out(input logic [W-1:0] v, input logic ri);
    step(1'b1, 1'b1, 2'b10, v, ri, 1'b0, '0, 1'b0);
  endtask

  task automatic net_in(input logic [W-1:0] v);
    step(1'b0, 1'b0, 2'b00, '0, 1'b0, 1'b1, v, 1'b0);
  endtask

  // Monitor: one expectation record per cycle, plus a read result the cycle after each read.
  bit rd_pend = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("net_si", W'(net_si), W'(e.si));
        check("net_ro", W'(net_ro), W'(e.ro));
        if (e.si) check("net_do", net_do, e.pkt);
        if (e.dz) check("reset_dout", d_out, '0);
      end
      if (rd_pend) begin
        if (rd_q.size() > 0) check("read_data", d_out, rd_q.pop_front());
        else check("read_queue_underflow", 64'd1, 64'd0);
      end
      rd_pend = nic_en && !nic_wr_en && !rst;
    end
  end

  initial begin
    rst = 1'b1; nic_en = 1'b0; nic_wr_en = 1'b0; addr = 2'b00; d_in = '0;
    net_ri = 1'b0; net_so = 1'b0; net_di = '0; net_polarity = 1'b0;
    m_in_last = '0; m_dz = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    armed = 1'b1;

    rd(2'b01, 1'b0);
    rd(2'b11, 1'b0);

    wr_out(64'h8000_0000_0000_00AA, 1'b1);
    idle(1'b1, 3);
    rd(2'b11, 1'b1);

    wr_out(64'h0000_0000_0000_1111, 1'b0);
    wr_out(64'h0000_0000_0000_0055, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 3);
    rd(2'b11, 1'b0);

    net_in(64'h0123_4567_89AB_CDEF);
    rd(2'b01, 1'b0);
    rd(2'b00, 1'b0);
    idle(1'b0, 1);

    net_in(64'h0000_0000_0000_BEEF);
    for (int i = 0; i < 3; i++) net_in(64'h0000_0000_0000_DEAD);
    step(1'b1, 1'b0, 2'b00, '0, 1'b0, 1'b1, 64'h0000_0000_0000_DEAD, 1'b0);
    net_in(64'h0000_0000_0000_DEAD);
    rd(2'b00, 1'b0);

    step(1'b1, 1'b0, 2'b00, '0, 1'b0, 1'b1, 64'h0000_0000_0000_CAFE, 1'b0);
    rd(2'b01, 1'b0);

    wr_out(64'h8000_0000_0000_0077, 1'b0);
    net_in(64'h0000_0000_0000_0099);
    step(1'b0, 1'b0, 2'b00, '0, 1'b1, 1'b0, '0, 1'b1);
    idle(1'b1, 2);
    rd(2'b01, 1'b1);
    rd(2'b11, 1'b1);

    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] dv;
      logic [W-1:0] nv;
      dv = {$urandom, $urandom};
      nv = {$urandom, $urandom};
      step($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), dv,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, nv, $urandom_range(0, 99) == 0);
    end

    idle(1'b0, 3);
    @(negedge clk);
    #1;
    armed = 1'b0;
    check("exp_queue_drained", W'(exp_q.size()), '0);
    check("rd_queue_drained", W'(rd_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
